// File: rtl/riscv_mem_pkg.sv
// Shared constants and types for the video/data RAM arbitration path.
package riscv_mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W_DEF   = DATA_W_DEF / 8;

  // CPU access tracker: WAIT is the single cycle in which cpu_ready is shown.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } cpu_state_t;

endpackage

// File: rtl/vram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM.
// VGA has priority; a streak counter forces a CPU grant after
// MAX_VGA_STREAK back-to-back VGA wins while the CPU is eligible.
//
// Handshake: the CPU holds cpu_req (and its attributes) until cpu_ready,
// which pulses for exactly one cycle, one cycle after its RAM slot. VGA
// presents vga_req/vga_addr; vga_gnt means the address was issued to RAM
// this cycle, and vga_rvalid/vga_rdata return that word one cycle later.
module vram_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int MAX_VGA_STREAK = 3
) (
  input  logic                                  clock_50,
  input  logic                                  reset_n,
  input  logic                                  cpu_req,
  input  logic                                  cpu_we,
  input  logic [DATA_W/8-1:0]                   cpu_be,
  input  logic [ADDR_W-1:0]                     cpu_addr,
  input  logic [DATA_W-1:0]                     cpu_wdata,
  output logic                                  cpu_ready,
  output logic [DATA_W-1:0]                     cpu_rdata,
  input  logic                                  vga_req,
  input  logic [ADDR_W-1:0]                     vga_addr,
  output logic                                  vga_gnt,
  output logic                                  vga_rvalid,
  output logic [DATA_W-1:0]                     vga_rdata,
  output logic                                  mem_en,
  output logic                                  mem_we,
  output logic [DATA_W/8-1:0]                   mem_be,
  output logic [ADDR_W-1:0]                     mem_addr,
  output logic [DATA_W-1:0]                     mem_wdata,
  input  logic [DATA_W-1:0]                     mem_rdata,
  output cpu_state_t                            dbg_state,
  output logic [$clog2(MAX_VGA_STREAK+1)-1:0]   dbg_streak
);

  localparam int BE_W = DATA_W / 8;
  localparam int SW   = $clog2(MAX_VGA_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_VGA_STREAK);

  cpu_state_t    state, state_nxt;
  logic [SW-1:0] streak, streak_nxt;
  logic          cpu_elig;
  logic          vga_win;
  logic          cpu_win;
  logic          cpu_rd_q;

  // Grant decision; gated by reset_n so nothing reaches the RAM in reset.
  always_comb begin
    cpu_elig = reset_n && (state == IDLE) && cpu_req;
    vga_win  = reset_n && vga_req && (!cpu_elig || (streak < STREAK_MAX));
    cpu_win  = cpu_elig && !vga_win;
  end

  // Next-state for the CPU tracker and the starvation counter.
  always_comb begin
    state_nxt  = IDLE;
    streak_nxt = '0;
    if (state == IDLE && cpu_win) state_nxt = WAIT;
    if (cpu_elig && vga_win) begin
      streak_nxt = (streak == STREAK_MAX) ? streak : streak + SW'(1);
    end
  end

  // State, streak, read/write flag of the CPU access and VGA return strobe.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      streak     <= '0;
      cpu_rd_q   <= 1'b0;
      vga_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      streak     <= streak_nxt;
      vga_rvalid <= vga_win;
      if (cpu_win) cpu_rd_q <= !cpu_we;
    end
  end

  // RAM port mux and response routing.
  always_comb begin
    mem_en    = vga_win || cpu_win;
    mem_we    = cpu_win && cpu_we;
    mem_be    = cpu_win ? cpu_be : {BE_W{1'b0}};
    mem_addr  = cpu_win ? cpu_addr : (vga_win ? vga_addr : {ADDR_W{1'b0}});
    mem_wdata = cpu_win ? cpu_wdata : {DATA_W{1'b0}};
    vga_gnt   = vga_win;
    vga_rdata = mem_rdata;
    cpu_ready = (state == WAIT);
    cpu_rdata = (cpu_ready && cpu_rd_q) ? mem_rdata : {DATA_W{1'b0}};
    dbg_state  = state;
    dbg_streak = streak;
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural synchronous RAM.
module tb_vram_arbiter;
  import riscv_mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clock_50 = 1'b0;
  logic        reset_n  = 1'b0;
  always #5 clock_50 = ~clock_50;

  logic        cpu_req = 0, cpu_we = 0;
  logic [3:0]  cpu_be = 0;
  logic [15:0] cpu_addr = 0;
  logic [31:0] cpu_wdata = 0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        vga_req = 0;
  logic [15:0] vga_addr = 0;
  logic        vga_gnt, vga_rvalid;
  logic [31:0] vga_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 0;
  cpu_state_t  dbg_state;
  logic [1:0]  dbg_streak;

  vram_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_VGA_STREAK(3)) dut (
    .clock_50(clock_50), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_streak(dbg_streak)
  );

  // ---------------- RAM model ----------------
  logic [31:0] ram [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 32'h0;
    for (int i = 0; i < 8; i++) ram[i] = 32'hA000_0000 + i;
    ram[16'h0010] = 32'hDEAD_BEEF;
  end

  // Synchronous single-port RAM, read-before-write, byte-lane writes.
  always @(posedge clock_50) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr];
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver helpers ----------------
  task automatic next_cycle();
    @(negedge clock_50);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset with both requesters active: nothing may reach the RAM.
    vga_req = 1; cpu_req = 1;
    next_cycle(); next_cycle(); #1;
    check("rst_state", dbg_state, IDLE);
    check("rst_streak", dbg_streak, 0);
    check("rst_ready", cpu_ready, 0);
    check("rst_rvalid", vga_rvalid, 0);
    check("rst_gnt", vga_gnt, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    next_cycle(); reset_n = 1; cpu_req = 0; vga_req = 0; #1;
    check("idle_mem_en", mem_en, 0);

    // CPU read, VGA idle.
    next_cycle(); cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010; #1;
    check("rd_en", mem_en, 1);
    check("rd_addr", mem_addr, 16'h0010);
    check("rd_we", mem_we, 0);
    check("rd_ready_t", cpu_ready, 0);
    next_cycle(); #1;
    check("rd_ready", cpu_ready, 1);
    check("rd_data", cpu_rdata, 32'hDEAD_BEEF);
    check("rd_no_regrant", mem_en, 0);
    next_cycle(); cpu_req = 0; #1;
    check("rd_ready_gone", cpu_ready, 0);
    check("rd_data_gone", cpu_rdata, 0);

    // CPU partial write then readback.
    next_cycle(); cpu_req = 1; cpu_we = 1; cpu_be = 4'b0011;
    cpu_addr = 16'h0020; cpu_wdata = 32'h1234_5678; #1;
    check("wr_en", mem_en, 1);
    check("wr_we", mem_we, 1);
    check("wr_be", mem_be, 4'b0011);
    check("wr_addr", mem_addr, 16'h0020);
    check("wr_wdata", mem_wdata, 32'h1234_5678);
    next_cycle(); #1;
    check("wr_ready", cpu_ready, 1);
    check("wr_rdata_zero", cpu_rdata, 0);
    next_cycle(); cpu_we = 0; cpu_be = 0; cpu_wdata = 0; #1;
    check("rb_en", mem_en, 1);
    check("rb_we", mem_we, 0);
    check("rb_be", mem_be, 0);
    next_cycle(); #1;
    check("rb_ready", cpu_ready, 1);
    check("rb_data", cpu_rdata, 32'h0000_5678);
    next_cycle(); cpu_req = 0; #1;

    // VGA streams words 0..7, CPU idle.
    for (int i = 0; i < 10; i++) begin
      next_cycle(); vga_req = (i < 8); vga_addr = 16'(i); #1;
      check("vga_gnt", vga_gnt, (i < 8));
      if (i < 8) check("vga_addr", mem_addr, 16'(i));
      if (vga_gnt) exp_q.push_back(32'hA000_0000 + i);
      if (i > 0) check("vga_rvalid", vga_rvalid, (i <= 8));
      if (vga_rvalid) begin
        if (exp_q.size() == 0) check("vga_extra_rvalid", 1, 0);
        else check("vga_rdata", vga_rdata, exp_q.pop_front());
      end
    end
    check("vga_q_empty", exp_q.size(), 0);

    // Continuous contention: per 5 cycles V,V,V,C then the WAIT-cycle V.
    for (int i = 0; i < 15; i++) begin
      next_cycle(); vga_req = 1; vga_addr = 16'h0040; cpu_req = 1; cpu_addr = 16'h0010; #1;
      check("both_gnt", vga_gnt, (i % 5 != 3));
      check("both_addr", mem_addr, (i % 5 == 3) ? 16'h0010 : 16'h0040);
      check("both_ready", cpu_ready, (i % 5 == 4));
      check("both_streak", dbg_streak, (i % 5 == 4) ? 0 : (i % 5));
      if (cpu_ready) check("both_rdata", cpu_rdata, 32'hDEAD_BEEF);
    end
    next_cycle(); vga_req = 0; cpu_req = 0; #1;
    check("both_quiet", mem_en, 0);

    // Reset while the access is in WAIT.
    next_cycle(); cpu_req = 1; cpu_addr = 16'h0010; #1;
    check("rw_grant", mem_en, 1);
    @(posedge clock_50); #1; reset_n = 0; #1;
    check("rw_state", dbg_state, IDLE);
    check("rw_mem_en_now", mem_en, 0);
    next_cycle(); #1;
    check("rw_ready", cpu_ready, 0);
    check("rw_mem_en", mem_en, 0);
    next_cycle(); reset_n = 1; #1;
    check("rw_regrant", mem_en, 1);
    check("rw_regrant_addr", mem_addr, 16'h0010);
    next_cycle(); #1;
    check("rw_ready_after", cpu_ready, 1);
    check("rw_rdata_after", cpu_rdata, 32'hDEAD_BEEF);
    next_cycle(); cpu_req = 0; #1;

    // VGA drops at streak 2: CPU wins, count restarts from zero.
    next_cycle(); vga_req = 1; vga_addr = 16'h0050; cpu_req = 1; cpu_addr = 16'h0010; #1;
    check("drop_gnt0", vga_gnt, 1);
    check("drop_streak0", dbg_streak, 0);
    next_cycle(); #1;
    check("drop_gnt1", vga_gnt, 1);
    check("drop_streak1", dbg_streak, 1);
    next_cycle(); vga_req = 0; #1;
    check("drop_streak2", dbg_streak, 2);
    check("drop_vga_off", vga_gnt, 0);
    check("drop_cpu_gnt", mem_addr, 16'h0010);
    check("drop_cpu_en", mem_en, 1);
    next_cycle(); vga_req = 1; #1;
    check("drop_wait_ready", cpu_ready, 1);
    check("drop_wait_gnt", vga_gnt, 1);
    check("drop_streak_clr", dbg_streak, 0);
    for (int k = 0; k < 4; k++) begin
      next_cycle(); #1;
      check("restart_streak", dbg_streak, k);
      check("restart_gnt", vga_gnt, (k < 3));
      check("restart_addr", mem_addr, (k < 3) ? 16'h0050 : 16'h0010);
    end
    next_cycle(); vga_req = 0; cpu_req = 0; #1;
    check("restart_ready", cpu_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

- Shares one single-port synchronous video/data RAM between two requesters:
  - the RISC-V pipeline's data-memory port (CPU);
  - the VGA scan-out pixel fetcher (VGA).
- Sits inside DE1_SoC between the core's load/store stage, the VGA controller and the RAM macro.
- VGA gets priority to protect display timing; a streak counter bounds CPU starvation.

## Interface
Parameters:
- ADDR_W, 16, word-address width
- DATA_W, 32, data width
- MAX_VGA_STREAK, 3, max consecutive VGA grants while the CPU waits (≥1)

Ports:
- clock_50  in  1  system clock; the only clock.
- reset_n  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  CPU access request; held until cpu_ready.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_be  in  DATA_W/8  byte enables (writes).
- cpu_addr  in  ADDR_W  word address.
- cpu_wdata  in  DATA_W  write data.
- cpu_ready  out  1  access complete (1-cycle pulse).
- cpu_rdata  out  DATA_W  read data, valid with cpu_ready on a read.
- vga_req  in  1  pixel fetch request.
- vga_addr  in  ADDR_W  pixel word address.
- vga_gnt  out  1  fetch accepted this cycle; VGA may advance its address next cycle.
- vga_rvalid  out  1  fetch data valid.
- vga_rdata  out  DATA_W  fetched pixel word.
- mem_en, mem_we  out  1  RAM enable / write enable.
- mem_be  out  DATA_W/8  RAM byte enables.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, 1 cycle after mem_en.

## Operation
- CPU FSM states:
  - IDLE: CPU is eligible when cpu_req=1.
  - WAIT: entered the cycle after a CPU grant. cpu_ready=1, CPU not eligible. Unconditionally returns to IDLE.
- Per-cycle grant:
  - only VGA requests → VGA;
  - only eligible CPU → CPU;
  - both → VGA if streak < MAX_VGA_STREAK, else CPU.
- Streak counter, width clog2(MAX_VGA_STREAK+1):
  - increments (saturating) on a VGA grant while CPU is eligible;
  - clears on a CPU grant or on any cycle the CPU is not eligible.
- RAM drive (combinational mux of the granted requester):
  - mem_en=1 on any grant;
  - mem_we=cpu_we and mem_be=cpu_be only on CPU grants; 0 otherwise;
  - idle cycle: all mem_* outputs 0.
- Read-data routing:
  - vga_rdata = mem_rdata; vga_rvalid is a registered copy of the VGA grant;
  - cpu_rdata = mem_rdata when cpu_ready and the access was a read, else 0.
- cpu_ready pulses for writes too; it is 1 cycle after the grant in both cases.

## Timing
- CPU access latency: grant at cycle t, cpu_ready at t+1. Maximum CPU throughput is 1 access per 2 cycles.
- Worst-case CPU wait from eligibility to grant: MAX_VGA_STREAK cycles.
- VGA is fully pipelined: one grant per cycle, rvalid at t+1 for each grant.
- A cycle with both cpu_ready (WAIT) and a VGA grant is legal.
- Reset values while reset_n=0:
  - state=IDLE, streak=0;
  - cpu_ready, vga_rvalid, vga_gnt, all mem_* = 0.
- Reset mid-access (e.g. in WAIT): the in-flight result is discarded with no cpu_ready. After release, the first eligible request is arbitrated fresh.
- No combinational path from cpu_req to cpu_ready.

## Structure
- Package riscv_mem_pkg:
  - ADDR_W/DATA_W defaults;
  - cpu_state_t enum {IDLE, WAIT};
  - byte-enable width constant.
- Single module, no sub-modules: grant logic, streak counter and WAIT flop are each under ~40 lines.

## Test plan
- CPU read, VGA idle, RAM[0x0010]=0xDEADBEEF:
  - mem_en=1, mem_addr=0x0010 at t;
  - cpu_ready=1, cpu_rdata=0xDEADBEEF at t+1;
  - next grant no earlier than t+2.
- CPU write 0x0020 ← 0x12345678, be=4'b0011:
  - mem_we=1, mem_be=0011 at t;
  - cpu_ready at t+1;
  - readback returns 0x00005678 over zero-initialised RAM.
- VGA streams addresses 0..7 every cycle, CPU idle:
  - vga_gnt every cycle;
  - vga_rvalid for data words 0..7 on 8 consecutive cycles, 1-cycle lag.
- Both request continuously, MAX_VGA_STREAK=3:
  - grant pattern V,V,V,C repeating (the WAIT cycle is also V);
  - every CPU access completes within 5 cycles of request.
- reset_n low during WAIT:
  - cpu_ready stays 0, mem_* = 0 immediately;
  - after release with cpu_req held, a fresh grant occurs and completes normally.
- vga_req drops when streak=2 while CPU waits:
  - CPU granted that cycle, streak=0;
  - next VGA-vs-CPU contention restarts the count from 0.
